// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one external add/sub ALU among N
//            requesters, with a tagged, back-pressured response channel.
//            Optional feature macro: ALU_ARB_STICKY_OVF_EN (sticky overflow).
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter  int W   = 8,
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_sub,
  input  logic [N-1:0]   req_signed,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_sub,
  output logic           alu_signed,
  input  logic [W-1:0]   alu_y,
  input  logic [3:0]     alu_flags,
`ifdef ALU_ARB_STICKY_OVF_EN
  input  logic [N-1:0]   sticky_clr,
  output logic [N-1:0]   sticky_ovf,
`endif
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_y,
  output logic [3:0]     rsp_flags
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Overflow flag position inside {C, V, Z, N}.
  localparam int C_FLAG_V = 2;

  state_t         state_q,     state_d;
  logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
  logic [IDW-1:0] id_q,        id_d;
  logic [W-1:0]   a_q,         a_d;
  logic [W-1:0]   b_q,         b_d;
  logic           sub_q,       sub_d;
  logic           signed_q,    signed_d;
  logic [W-1:0]   rsp_y_q,     rsp_y_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;
  logic           ready_en_q,  ready_en_d;

  logic           w_grant_found;
  logic [IDW-1:0] w_grant_idx;
  logic [N-1:0]   w_grant_onehot;

  // First valid requester at or after rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    int j;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!w_grant_found && req_valid[j]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDW'(j);
      end
    end
  end

  always_comb begin
    w_grant_onehot              = '0;
    w_grant_onehot[w_grant_idx] = 1'b1;
  end

  // ready_en_q keeps req_ready low from reset until the first clock edge.
  assign req_ready = (state_q == ST_IDLE && ready_en_q && w_grant_found)
                     ? w_grant_onehot : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    signed_d    = signed_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    ready_en_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (ready_en_q && w_grant_found) begin
          id_d     = w_grant_idx;
          a_d      = req_a[int'(w_grant_idx)*W +: W];
          b_d      = req_b[int'(w_grant_idx)*W +: W];
          sub_d    = req_sub[w_grant_idx];
          signed_d = req_signed[w_grant_idx];
          rr_ptr_d = (int'(w_grant_idx) == N-1) ? '0 : w_grant_idx + 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_y_d     = alu_y;
        rsp_flags_d = alu_flags;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      signed_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      signed_q    <= signed_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      ready_en_q  <= ready_en_d;
    end
  end

`ifdef ALU_ARB_STICKY_OVF_EN
  logic [N-1:0] sticky_ovf_q, sticky_ovf_d;

  // Clear is applied after set so that a same-cycle clear wins.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    if (state_q == ST_EXEC && alu_flags[C_FLAG_V]) begin
      sticky_ovf_d[id_q] = 1'b1;
    end
    sticky_ovf_d = sticky_ovf_d & ~sticky_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf_q <= '0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
`endif

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sub    = sub_q;
  assign alu_signed = signed_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_flags  = rsp_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed, table-driven bench for alu_share_arbiter (W=8, N=4)
//            with a behavioural model of the external add/sub ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_signed;
  logic [W-1:0]   alu_a, alu_b, alu_y;
  logic           alu_sub, alu_signed;
  logic [3:0]     alu_flags;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_y;
  logic [3:0]     rsp_flags;
`ifdef ALU_ARB_STICKY_OVF_EN
  logic [N-1:0]   sticky_clr;
  logic [N-1:0]   sticky_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .req_signed (req_signed),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sub    (alu_sub),
    .alu_signed (alu_signed),
    .alu_y      (alu_y),
    .alu_flags  (alu_flags),
`ifdef ALU_ARB_STICKY_OVF_EN
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_flags  (rsp_flags)
  );

  // External ALU model: flags are {carry_no_borrow, overflow, zero, negative}.
  logic [W:0] alu_t;
  always_comb begin
    if (alu_sub) alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
    else         alu_t = {1'b0, alu_a} + {1'b0, alu_b};
    alu_y        = alu_t[W-1:0];
    alu_flags[3] = alu_t[W];
    alu_flags[2] = alu_signed & (alu_sub
                   ? (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1])
                   : (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]));
    alu_flags[1] = (alu_y == '0);
    alu_flags[0] = alu_y[W-1];
  end

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       sgn;
    logic [7:0] exp_y;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic sgn);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_sub[id]      = sub;
    req_signed[id]   = sgn;
    req_valid[id]    = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts and ends one time unit after a rising edge, with the DUT idle.
  task automatic run_op(input vec_t v);
    logic [3:0] exp_rdy;
    int c;
    exp_rdy = 4'b0001 << v.id;
    set_req(v.id, v.a, v.b, v.sub, v.sgn);
    @(negedge clk);
    c = 0;
    while (req_ready !== exp_rdy && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("op_grant", {28'd0, req_ready}, {28'd0, exp_rdy});
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    @(negedge clk);
    chk("op_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("op_exec_alu_a", {24'd0, alu_a}, {24'd0, v.a});
    chk("op_exec_req_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("op_rsp_id", {30'd0, rsp_id}, v.id);
    chk("op_rsp_y", {24'd0, rsp_y}, {24'd0, v.exp_y});
    chk("op_rsp_flags", {28'd0, rsp_flags}, {28'd0, v.exp_flags});
    @(posedge clk); #1;
    @(negedge clk);
    chk("op_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rr_y[4];
    int c;
    vecs[0] = '{0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 4'b0101};
    vecs[1] = '{2, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 4'b1010};
    vecs[2] = '{1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1010};
    vecs[3] = '{3, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 4'b1100};
    vecs[4] = '{1, 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 4'b0001};
    vecs[5] = '{3, 8'h40, 8'h40, 1'b0, 1'b1, 8'h80, 4'b0101};
    rr_y = '{8'h01, 8'h12, 8'h23, 8'h34};

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    req_signed = '0;
    rsp_ready  = 1'b1;
`ifdef ALU_ARB_STICKY_OVF_EN
    sticky_clr = '0;
`endif
    req_valid  = 4'b0001;
    #1;
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_y", {24'd0, rsp_y}, 32'd0);
    chk("reset_alu_a", {24'd0, alu_a}, 32'd0);
    req_valid = '0;
    #6;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i]);
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    pulse_reset();
    chk("sticky_reset", {28'd0, sticky_ovf}, 32'd0);
    run_op(vecs[0]);
    chk("sticky_set", {28'd0, sticky_ovf}, 32'd1);
    sticky_clr = 4'b0001;
    @(posedge clk); #1;
    sticky_clr = '0;
    chk("sticky_clr", {28'd0, sticky_ovf}, 32'd0);
    sticky_clr = 4'b0001;
    run_op(vecs[0]);
    sticky_clr = '0;
    chk("sticky_clr_wins", {28'd0, sticky_ovf}, 32'd0);
`endif

    // Round-robin with every requester continuously valid.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 8'(i * 16 + 1), 8'(i), 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      c = 0;
      while (req_ready === '0 && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("rr_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
      @(posedge clk); #1;
      @(negedge clk);
      c = 0;
      while (rsp_valid !== 1'b1 && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("rr_rsp_id", {30'd0, rsp_id}, k % 4);
      chk("rr_rsp_y", {24'd0, rsp_y}, {24'd0, rr_y[k % 4]});
      @(posedge clk); #1;
    end

    // Backpressure in RESP: requester 2 is next after the round above.
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", {28'd0, req_ready}, 32'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    c = 0;
    while (rsp_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_y", {24'd0, rsp_y}, 32'h23);
      chk("bp_hold_id", {30'd0, rsp_id}, 32'd2);
      chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant", {28'd0, req_ready}, 32'b1000);
    req_valid = '0;
    @(posedge clk); #1;

    // Asynchronous reset while a response for requester 1 is held.
    rsp_ready    = 1'b0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    c = 0;
    while (req_ready !== 4'b0010 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rst_grant1", {28'd0, req_ready}, 32'b0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    req_valid = 4'b0011;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_y", {24'd0, rsp_y}, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_before_clk", {28'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_next_grant", {28'd0, req_ready}, 32'b0001);
    req_valid = '0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
